sprite_motion_ctrl: RTL

- Per-frame motion scheduler for the screensaver sprite: a bouncing logo.
- Watches the video timer's 32-bit frame counter and, once per N frames, advances a sprite origin (x, y) by a fixed step.
- Reflects the sprite off the visible-area edges and advances a colour index on every bounce.
- Outputs feed the image generator; they change atomically, once per update, never mid-frame-line.

---
 rtl/sprite_motion_pkg.sv | 26 ++
 rtl/sprite_motion_ctrl_axis.sv | 56 +++++
 rtl/sprite_motion_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_pkg.sv
// Shared types and helpers for the bouncing-sprite motion scheduler.
//   state_t  : sequencer states
//   dir_t    : per-axis travel direction
//   axis_max : largest legal origin on an axis (screen extent minus sprite extent)
package sprite_motion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC_X = 2'd1,
      CALC_Y = 2'd2,
      COMMIT = 2'd3
   } state_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   localparam int X_BITS = 10;
   localparam int Y_BITS = 9;

   function automatic int axis_max(input int screen, input int sprite);
      return screen - sprite;
   endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis.sv
// bounce_axis: one axis of the sprite motion. Steps the position by STEP in
// the current direction, clamps onto the edge (0 or MAX) and reflects.
//   pos  : current origin on this axis
//   dir  : current direction
//   npos : next origin, always within 0..MAX
//   ndir : next direction (flipped when an edge is reached)
//   hit  : the edge was reached on this step
module bounce_axis
   import sprite_motion_pkg::*;
#(
   parameter int W    = 10,
   parameter int STEP = 2,
   parameter int MAX  = 576
) (
   input  logic [W-1:0] pos,
   input  dir_t         dir,
   output logic [W-1:0] npos,
   output dir_t         ndir,
   output logic         hit
);

   localparam int         WE     = W + 1;
   localparam logic [W:0] STEP_E = WE'(STEP);
   localparam logic [W:0] MAX_E  = WE'(MAX);

   // One extra bit so pos+STEP cannot wrap before the edge compare.
   logic [W:0] pos_e;
   logic [W:0] sum_e;

   assign pos_e = {1'b0, pos};
   assign sum_e = pos_e + STEP_E;

   always_comb begin
      npos = pos;
      ndir = dir;
      hit  = 1'b0;
      if (dir == DIR_POS) begin
         if (sum_e >= MAX_E) begin
            npos = MAX_E[W-1:0];
            ndir = DIR_NEG;
            hit  = 1'b1;
         end else begin
            npos = sum_e[W-1:0];
         end
      end else begin
         if (pos_e <= STEP_E) begin
            npos = '0;
            ndir = DIR_POS;
            hit  = 1'b1;
         end else begin
            npos = pos - STEP_E[W-1:0];
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame motion scheduler for the bouncing logo.
// Every FRAME_DIV frame changes it steps the sprite origin by STEP on both
// axes, reflecting off the visible-area edges and advancing the palette index
// on each bounce. All outputs change together, once per update.
//   clk_25_175 : pixel clock
//   rst        : asynchronous, active-high reset
//   enable     : 0 freezes position/colour (frame tracking continues)
//   frame      : frame counter from the video timer
//   sprite_x   : sprite left edge, 0..SCREEN_W-SPRITE_W
//   sprite_y   : sprite top edge, 0..SCREEN_H-SPRITE_H
//   color_idx  : current palette entry
//   bounce     : one-cycle pulse after a commit where an axis reflected
//   corner     : one-cycle pulse after a commit where both axes reflected
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | waiting for an update request (new or pending)
// CALC_X | x step/clamp/reflect captured into temporaries
// CALC_Y | y step/clamp/reflect captured into temporaries
// COMMIT | position, directions and colour written together
module sprite_motion_ctrl
   import sprite_motion_pkg::*;
#(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int SPRITE_W   = 64,
   parameter int SPRITE_H   = 32,
   parameter int STEP       = 2,
   parameter int FRAME_DIV  = 1,
   parameter int NUM_COLORS = 8
) (
   input  logic                          clk_25_175,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [31:0]                   frame,
   output logic [X_BITS-1:0]             sprite_x,
   output logic [Y_BITS-1:0]             sprite_y,
   output logic [$clog2(NUM_COLORS)-1:0] color_idx,
   output logic                          bounce,
   output logic                          corner
);

   localparam int XMAX = axis_max(SCREEN_W, SPRITE_W);
   localparam int YMAX = axis_max(SCREEN_H, SPRITE_H);
   localparam int CW   = $clog2(NUM_COLORS);
   localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   state_t            state, state_d;
   logic [31:0]       frame_q;
   logic [DW-1:0]     div_cnt;
   logic              pending, pending_d;
   dir_t              dir_x, dir_y;
   logic [X_BITS-1:0] nx_q;
   logic [Y_BITS-1:0] ny_q;
   dir_t              ndx_q, ndy_q;
   logic              hx_q, hy_q;

   logic              tick, div_last, req;
   logic [X_BITS-1:0] ax_npos;
   logic [Y_BITS-1:0] ay_npos;
   dir_t              ax_ndir, ay_ndir;
   logic              ax_hit, ay_hit;

   // Inequality rather than increment detect, so the 0xFFFFFFFF->0 wrap counts.
   assign tick     = (frame != frame_q);
   assign div_last = (div_cnt == DW'(FRAME_DIV - 1));
   assign req      = tick && enable && div_last;

   bounce_axis #(.W(X_BITS), .STEP(STEP), .MAX(XMAX)) u_axis_x (
      .pos  (sprite_x),
      .dir  (dir_x),
      .npos (ax_npos),
      .ndir (ax_ndir),
      .hit  (ax_hit)
   );

   bounce_axis #(.W(Y_BITS), .STEP(STEP), .MAX(YMAX)) u_axis_y (
      .pos  (sprite_y),
      .dir  (dir_y),
      .npos (ay_npos),
      .ndir (ay_ndir),
      .hit  (ay_hit)
   );

   always_ff @(posedge clk_25_175 or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d   = state;
      pending_d = pending;
      case (state)
         IDLE: begin
            if (req || (pending && enable)) begin
               state_d = CALC_X;
            end
         end
         CALC_X:  state_d = CALC_Y;
         CALC_Y:  state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Single-entry queue. In IDLE one request is consumed; if a queued and a
      // fresh request meet there, the fresh one stays queued.
      if (!enable) begin
         pending_d = 1'b0;
      end else if (state == IDLE) begin
         pending_d = pending && req;
      end else if (req) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_25_175 or posedge rst) begin
      if (rst) begin
         frame_q   <= '0;
         div_cnt   <= '0;
         pending   <= 1'b0;
         sprite_x  <= '0;
         sprite_y  <= '0;
         color_idx <= '0;
         bounce    <= 1'b0;
         corner    <= 1'b0;
         dir_x     <= DIR_POS;
         dir_y     <= DIR_POS;
         nx_q      <= '0;
         ny_q      <= '0;
         ndx_q     <= DIR_POS;
         ndy_q     <= DIR_POS;
         hx_q      <= 1'b0;
         hy_q      <= 1'b0;
      end else begin
         frame_q <= frame;
         pending <= pending_d;
         bounce  <= 1'b0;
         corner  <= 1'b0;
         if (tick && enable) begin
            div_cnt <= div_last ? '0 : div_cnt + DW'(1);
         end
         case (state)
            CALC_X: begin
               nx_q  <= ax_npos;
               ndx_q <= ax_ndir;
               hx_q  <= ax_hit;
            end
            CALC_Y: begin
               ny_q  <= ay_npos;
               ndy_q <= ay_ndir;
               hy_q  <= ay_hit;
            end
            COMMIT: begin
               sprite_x <= nx_q;
               sprite_y <= ny_q;
               dir_x    <= ndx_q;
               dir_y    <= ndy_q;
               // A corner still advances the palette by exactly one entry.
               if (hx_q || hy_q) begin
                  color_idx <= (color_idx == CW'(NUM_COLORS - 1)) ? '0 : color_idx + CW'(1);
               end
               bounce <= hx_q || hy_q;
               corner <= hx_q && hy_q;
            end
            default: ;
         endcase
      end
   end

endmodule
